mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 Parameter MEM_LATENCY, default 4: write cycles from mem_en to completion; legal range 1..63.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 req_valid  in  1  LW/SW request from the execute stage.
REQ-006 req_wr  in  1  1 = SW, 0 = LW.
REQ-007 req_addr  in  16  computed memory address from the ALU.
REQ-008 req_wdata  in  16  store data.
REQ-009 req_ready  out  1  request is accepted this cycle.
REQ-010 stall  out  1  pipeline hold.
REQ-011 mem_en, mem_wr  out  1 each  memory strobe and write select.
REQ-012 mem_addr, mem_data_in  out  16 each  memory address and write data.
REQ-013 mem_data_out  in  16  memory read data.
REQ-014 mem_data_valid  in  1  read data is valid.
REQ-015 rd_data  out  16  load result.
REQ-016 rd_valid  out  1  load result is valid.
REQ-017 done  out  1  access complete.
REQ-018 align_err  out  1  misaligned address flag.
REQ-019 timeout_err  out  1  read timeout flag.

Function
REQ-020 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-021 req_ready SHALL be 1 only in IDLE; the block SHALL accept a request when req_valid & req_ready.
REQ-022 On accept, the block SHALL latch {req_addr[15:1],1'b0}, req_wdata, req_wr and req_addr[0], then go to BUSY with cnt=1.
REQ-023 mem_en SHALL be 1 for exactly the first BUSY cycle. mem_addr, mem_wr and mem_data_in SHALL hold the latched values throughout BUSY and be 0 otherwise.
REQ-024 cnt SHALL be 8 bits and SHALL increment on every BUSY cycle.
REQ-025 A write SHALL leave BUSY when cnt==MEM_LATENCY.
REQ-026 A read SHALL leave BUSY on the first BUSY cycle with mem_data_valid=1, including the mem_en cycle, and SHALL capture mem_data_out into rd_data.
REQ-027 mem_data_valid SHALL be ignored in IDLE and DONE and during writes.
REQ-028 DONE SHALL last exactly one cycle with done=1. rd_valid SHALL be 1 in DONE for reads only. The next state SHALL be IDLE.
REQ-029 rd_data SHALL hold its value until the next read completes.
REQ-030 align_err SHALL be 1 in DONE when the latched req_addr[0] is 1; the access SHALL still proceed to the even address.
REQ-031 stall SHALL equal req_valid & ~done, combinationally.
REQ-032 If req_valid is high during DONE, the request SHALL not be accepted until the following IDLE cycle.

Reset
REQ-033 rst SHALL immediately force IDLE and cnt=0, and set all outputs to 0 (req_ready becomes 1 once IDLE), including mid-BUSY.
REQ-034 An in-flight access aborted by reset SHALL produce no done, rd_valid or rd_data update.

Configuration
REQ-035 Macro MEM_ACCESS_CTRL_TIMEOUT_EN.
REQ-036 With MEM_ACCESS_CTRL_TIMEOUT_EN defined: a read still in BUSY at cnt==4*MEM_LATENCY without mem_data_valid SHALL go to DONE with timeout_err=1 and rd_data=16'hFFFF.
REQ-037 Without MEM_ACCESS_CTRL_TIMEOUT_EN: reads wait indefinitely, cnt saturates at 255, and timeout_err is tied to 0 (the port remains present).

Structure
REQ-038 Package mem_access_pkg SHALL hold the state enum, the TIMEOUT_DATA constant (16'hFFFF) and the ADDR_ALIGN_MASK constant (16'hFFFE).
REQ-039 Sub-module mac_cycle_counter SHALL implement the 8-bit saturating BUSY counter with clear and enable.

Verification (MEM_LATENCY=4, accept at T0)
REQ-040 SW addr 16'h0010, data 16'hBEEF -> T1: mem_en=1, mem_wr=1, mem_addr=16'h0010, mem_data_in=16'hBEEF; T5: done=1, rd_valid=0; T6: req_ready=1.
REQ-041 LW addr 16'h0020 with mem_data_valid=1 and mem_data_out=16'h1234 at T4 -> T5: done=1, rd_valid=1, rd_data=16'h1234; stall=1 for T0..T4.
REQ-042 LW addr 16'h0031 -> mem_addr=16'h0030 during BUSY; align_err=1 at DONE.
REQ-043 rst pulsed at T2 of a read -> mem_en=0 immediately, state IDLE, no done pulse, rd_data unchanged at 0.
REQ-044 MEM_ACCESS_CTRL_TIMEOUT_EN defined, LW with no mem_data_valid -> T17: done=1, timeout_err=1, rd_data=16'hFFFF; without the macro, still BUSY at T40.
REQ-045 Back-to-back requests with req_valid held high -> second accept at T6, not at T5.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the LW/SW memory access controller.
// Holds the FSM state enum, timeout read data and address alignment mask.
package mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int          CNT_W           = 8;
    localparam logic [15:0] TIMEOUT_DATA    = 16'hFFFF;
    localparam logic [15:0] ADDR_ALIGN_MASK = 16'hFFFE;

endpackage

// File: rtl/mac_cycle_counter.sv
// 8-bit saturating cycle counter used to time BUSY accesses.
// Ports: clk, rst (async, active-high), clear, enable, cnt[7:0].
module mac_cycle_counter
    import mem_access_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// LW/SW memory access controller: IDLE -> BUSY -> DONE handshake FSM.
// Ports: req_* from execute, mem_* to/from memory, rd_*/done/err results.
// Optional `MEM_ACCESS_CTRL_TIMEOUT_EN: reads give up at 4*MEM_LATENCY.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out,
    input  logic        mem_data_valid,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic        align_err,
    output logic        timeout_err
);

    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MEM_LATENCY);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      lat_addr;
    logic [15:0]      lat_wdata;
    logic             lat_wr;
    logic             lat_odd;
    logic [15:0]      rd_data_q;

    logic in_idle;
    logic in_busy;
    logic in_done;
    logic accept;
    logic rd_hit;
    logic wr_fin;
    logic rd_tmo;

    assign in_idle = (state == ST_IDLE);
    assign in_busy = (state == ST_BUSY);
    assign in_done = (state == ST_DONE);
    assign accept  = in_idle & req_valid;

    // Read data is only sampled while a read is in BUSY.
    assign rd_hit = in_busy & ~lat_wr & mem_data_valid;
    assign wr_fin = in_busy & lat_wr & (cnt == LAT_CNT);

`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(4 * MEM_LATENCY);
    logic tmo_q;

    assign rd_tmo = in_busy & ~lat_wr & ~mem_data_valid & (cnt == TMO_CNT);
`else
    assign rd_tmo = 1'b0;
`endif

    // Counter reaches 1 on the first BUSY cycle because it counts the
    // accept edge; it is held cleared outside of an access.
    mac_cycle_counter u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (~in_busy & ~accept),
        .enable (accept | in_busy),
        .cnt    (cnt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (rd_hit || wr_fin || rd_tmo) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wr    <= 1'b0;
            lat_odd   <= 1'b0;
        end else if (accept) begin
            lat_addr  <= req_addr & ADDR_ALIGN_MASK;
            lat_wdata <= req_wdata;
            lat_wr    <= req_wr;
            lat_odd   <= req_addr[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_hit) begin
            rd_data_q <= mem_data_out;
        end else if (rd_tmo) begin
            rd_data_q <= TIMEOUT_DATA;
        end
    end

`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= 1'b0;
        end else if (accept) begin
            tmo_q <= 1'b0;
        end else if (rd_tmo) begin
            tmo_q <= 1'b1;
        end
    end

    assign timeout_err = in_done & tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign req_ready   = in_idle;
    assign stall       = req_valid & ~done;
    assign mem_en      = in_busy & (cnt == CNT_W'(1));
    assign mem_wr      = in_busy & lat_wr;
    assign mem_addr    = in_busy ? lat_addr : 16'h0000;
    assign mem_data_in = in_busy ? lat_wdata : 16'h0000;
    assign done        = in_done;
    assign rd_valid    = in_done & ~lat_wr;
    assign align_err   = in_done & lat_odd;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with MEM_LATENCY=4.
// Random LW/SW traffic checked against a transaction-level model.
module tb_mem_access_ctrl;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_wr = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        req_ready;
    logic        stall;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out = '0;
    logic        mem_data_valid = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        align_err;
    logic        timeout_err;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_rd = 16'h0000;

    mem_access_ctrl #(.MEM_LATENCY(LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .stall          (stall),
        .mem_en         (mem_en),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .mem_data_valid (mem_data_valid),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .done           (done),
        .align_err      (align_err),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outputs that must be quiet whenever no access is in BUSY/DONE.
    task automatic check_idle(input string tag);
        check({tag, "_ready"}, req_ready, 1);
        check({tag, "_stall"}, stall, 32'(req_valid));
        check({tag, "_memen"}, mem_en, 0);
        check({tag, "_memwr"}, mem_wr, 0);
        check({tag, "_maddr"}, mem_addr, 0);
        check({tag, "_mdin"}, mem_data_in, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rdv"}, rd_valid, 0);
        check({tag, "_aerr"}, align_err, 0);
        check({tag, "_terr"}, timeout_err, 0);
        check({tag, "_rdata"}, rd_data, 32'(exp_rd));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'b0;
            req_wr = 1'($urandom);
            req_addr = 16'($urandom);
            mem_data_valid = 1'($urandom);
            mem_data_out = 16'($urandom);
            @(negedge clk);
            check_idle("idle");
            step();
        end
    endtask

    // One whole access, entered on an IDLE cycle. The number of BUSY
    // cycles follows from the access rules: writes take LAT cycles,
    // reads end on the valid cycle vat, vat==0 means no data ever
    // (timeout). req_valid in the DONE cycle is keep_valid.
    task automatic run_txn(input bit wr, input logic [15:0] addr,
                           input logic [15:0] wdata,
                           input logic [15:0] rdata, input int vat,
                           input bit keep_valid);
        bit tmo;
        int n;
        logic [15:0] ea;
        tmo = !wr && (vat == 0);
        n = wr ? LAT : (tmo ? 4 * LAT : vat);
        ea = addr & 16'hFFFE;
        req_valid = 1'b1;
        req_wr = wr;
        req_addr = addr;
        req_wdata = wdata;
        mem_data_valid = 1'($urandom);
        mem_data_out = 16'($urandom);
        @(negedge clk);
        check("acc_ready", req_ready, 1);
        check("acc_stall", stall, 1);
        check("acc_memen", mem_en, 0);
        check("acc_done", done, 0);
        step();
        for (int k = 1; k <= n; k++) begin
            req_wr = 1'($urandom);
            req_addr = 16'($urandom);
            req_wdata = 16'($urandom);
            mem_data_out = 16'($urandom);
            if (wr) begin
                mem_data_valid = 1'($urandom);
            end else begin
                mem_data_valid = (k == vat);
                if (k == vat) mem_data_out = rdata;
            end
            @(negedge clk);
            check("busy_ready", req_ready, 0);
            check("busy_stall", stall, 1);
            check("busy_done", done, 0);
            check("busy_rdv", rd_valid, 0);
            check("busy_memen", mem_en, 32'(k == 1));
            check("busy_memwr", mem_wr, 32'(wr));
            check("busy_maddr", mem_addr, 32'(ea));
            check("busy_mdin", mem_data_in, 32'(wdata));
            step();
        end
        if (!wr) exp_rd = tmo ? 16'hFFFF : rdata;
        req_valid = keep_valid;
        mem_data_valid = 1'($urandom);
        mem_data_out = 16'($urandom);
        @(negedge clk);
        check("done_done", done, 1);
        check("done_rdv", rd_valid, 32'(!wr));
        check("done_rdata", rd_data, 32'(exp_rd));
        check("done_aerr", align_err, 32'(addr[0]));
        check("done_terr", timeout_err, 32'(tmo));
        check("done_ready", req_ready, 0);
        check("done_stall", stall, 0);
        check("done_memen", mem_en, 0);
        check("done_maddr", mem_addr, 0);
        check("done_mdin", mem_data_in, 0);
        check("done_memwr", mem_wr, 0);
        step();
    endtask

    // Start a read and let it sit in BUSY for busy_n cycles, then reset
    // asynchronously in the middle of the next cycle.
    task automatic read_then_reset(input logic [15:0] addr,
                                   input int busy_n);
        req_valid = 1'b1;
        req_wr = 1'b0;
        req_addr = addr;
        mem_data_valid = 1'b0;
        @(negedge clk);
        check("rr_acc_ready", req_ready, 1);
        step();
        for (int k = 1; k <= busy_n; k++) begin
            @(negedge clk);
            check("rr_busy_ready", req_ready, 0);
            check("rr_busy_done", done, 0);
            check("rr_busy_memen", mem_en, 32'(k == 1));
            check("rr_busy_maddr", mem_addr, 32'(addr & 16'hFFFE));
            step();
        end
        #2;
        rst = 1'b1;
        #1;
        exp_rd = 16'h0000;
        check("rst_memen", mem_en, 0);
        check("rst_maddr", mem_addr, 0);
        check("rst_ready", req_ready, 1);
        check("rst_done", done, 0);
        check("rst_rdata", rd_data, 0);
        step();
        rst = 1'b0;
        idle(3);
    endtask

    initial begin
        @(negedge clk);
        check_idle("por");
        step();
        rst = 1'b0;
        idle(2);

        read_then_reset(16'h0040, 2);

`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
        run_txn(1'b0, 16'h0050, 16'h0000, 16'h0000, 0, 1'b0);
        idle(1);
`else
        // No timeout: the read must stay in BUSY well past the point
        // where an 8-bit count would wrap.
        read_then_reset(16'h0050, 300);
`endif

        run_txn(1'b1, 16'h0010, 16'hBEEF, 16'h0000, 0, 1'b0);
        idle(1);
        run_txn(1'b0, 16'h0020, 16'h0000, 16'h1234, 4, 1'b0);
        idle(1);
        run_txn(1'b0, 16'h0031, 16'h0000, 16'h5A5A, 2, 1'b1);
        run_txn(1'b1, 16'h0033, 16'h7777, 16'h0000, 0, 1'b1);
        run_txn(1'b0, 16'h0044, 16'h0000, 16'hC3C3, 1, 1'b0);

        for (int t = 0; t < 60; t++) begin
            bit wr;
            int vat;
            wr = 1'($urandom);
            vat = $urandom_range(1, 8);
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
            if ($urandom_range(0, 7) == 0) vat = 0;
`endif
            run_txn(wr, 16'($urandom), 16'($urandom), 16'($urandom),
                    vat, 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
